// File: rtl/cnt_seq_decoder_pkg.sv
// Shared types for the count-sequence decoder: FSM states, step classes, direction encoding.
package cnt_dec_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACQ   = 2'd1,
    S_UP    = 2'd2,
    S_DN    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DN   = 2'd1,
    STEP_HOLD = 2'd2,
    STEP_BAD  = 2'd3
  } step_t;

  // Same encoding as the counter's U_D input
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int RUN_W = 4;

endpackage

// File: rtl/cnt_seq_decoder_if.sv
// Sample stream in, recovered direction and status out.
interface cnt_seq_decoder_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] cnt_in;
  logic             dir;
  logic             locked;
  logic             wrap;
  logic             rev;
  logic             err;
  logic [7:0]       err_cnt;

  modport master (
    output en, cnt_in,
    input  dir, locked, wrap, rev, err, err_cnt
  );

  modport slave (
    input  en, cnt_in,
    output dir, locked, wrap, rev, err, err_cnt
  );
endinterface

// File: rtl/cnt_seq_decoder_step_classify.sv
// Classifies one count step p -> c as up, down, hold or illegal, and flags legal wraps.
module cnt_step_classify
  import cnt_dec_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 15
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] c,
  output step_t            step,
  output logic             is_wrap
);

  int p_i;
  int c_i;

  always_comb begin
    p_i     = int'(p);
    c_i     = int'(c);
    step    = STEP_BAD;
    is_wrap = 1'b0;
    if (c_i < MIN || c_i > MAX) begin
      step = STEP_BAD;
    end else if (c_i == p_i) begin
      step = STEP_HOLD;
    end else if (p_i == MAX && c_i == MIN) begin
      step    = STEP_UP;
      is_wrap = 1'b1;
    end else if (p_i == MIN && c_i == MAX) begin
      step    = STEP_DN;
      is_wrap = 1'b1;
    end else if (p_i != MAX && c_i == p_i + 1) begin
      step = STEP_UP;
    end else if (p_i != MIN && c_i == p_i - 1) begin
      step = STEP_DN;
    end
  end

endmodule

// File: rtl/cnt_seq_decoder.sv
// Recovers counting direction and lock from an observed MIN..MAX count stream.
// state   | meaning
// S_EMPTY | no valid previous sample
// S_ACQ   | previous sample held, direction unknown
// S_UP    | tracking an up count
// S_DN    | tracking a down count
module cnt_seq_decoder
  import cnt_dec_pkg::*;
#(
  parameter int MAX    = 15,
  parameter int MIN    = 0,
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2
) (
  input logic              clk,
  input logic              rst_n,
  cnt_seq_decoder_if.slave bus
);

  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_N);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               dir_q, dir_d;
  logic               locked_q, locked_d;
  logic               wrap_q, wrap_d;
  logic               rev_q, rev_d;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q;
  step_t              step;
  logic               is_wrap;
  logic               c_ok;
  logic               same_dir;

  cnt_step_classify #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX)
  ) u_classify (
    .p       (p_q),
    .c       (bus.cnt_in),
    .step    (step),
    .is_wrap (is_wrap)
  );

  assign c_ok     = (int'(bus.cnt_in) >= MIN) && (int'(bus.cnt_in) <= MAX);
  assign same_dir = (state_q == S_UP && step == STEP_UP) ||
                    (state_q == S_DN && step == STEP_DN);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    run_d    = run_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    wrap_d   = 1'b0;
    rev_d    = 1'b0;
    err_d    = 1'b0;
    if (bus.en) begin
      if (state_q == S_EMPTY) begin
        if (c_ok) begin
          p_d     = bus.cnt_in;
          state_d = S_ACQ;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (step)
          STEP_UP, STEP_DN: begin
            p_d    = bus.cnt_in;
            wrap_d = is_wrap;
            if (same_dir) begin
              run_d = (run_q >= LOCK_V) ? run_q : run_q + 1'b1;
            end else begin
              // A first step out of S_ACQ sets direction but is not a reversal
              rev_d   = (state_q != S_ACQ);
              run_d   = 4'd1;
              state_d = (step == STEP_UP) ? S_UP : S_DN;
              dir_d   = (step == STEP_UP) ? DIR_UP : DIR_DN;
            end
          end
          STEP_BAD: begin
            err_d = 1'b1;
            run_d = '0;
            if (c_ok) begin
              p_d     = bus.cnt_in;
              state_d = S_ACQ;
            end else begin
              state_d = S_EMPTY;
            end
          end
          default: ;
        endcase
      end
      locked_d = (state_d == S_UP || state_d == S_DN) && (run_d >= LOCK_V) &&
                 !rev_d && !err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      p_q       <= '0;
      run_q     <= '0;
      dir_q     <= DIR_UP;
      locked_q  <= 1'b0;
      wrap_q    <= 1'b0;
      rev_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      wrap_q   <= wrap_d;
      rev_q    <= rev_d;
      err_q    <= err_d;
      if (err_d && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.dir     = dir_q;
  assign bus.locked  = locked_q;
  assign bus.wrap    = wrap_q;
  assign bus.rev     = rev_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cnt_seq_decoder.sv
// Bench for cnt_seq_decoder: directed scenarios plus random walks, checked against a modular-arithmetic model.
module tb_cnt_seq_decoder;

  typedef struct {
    bit has_p;
    int p;
    int trk;
    int run;
    bit dir;
    bit locked;
    bit wrap;
    bit rev;
    bit err;
    int err_cnt;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  cnt_seq_decoder_if #(.WIDTH(4)) if_a ();
  cnt_seq_decoder_if #(.WIDTH(4)) if_b ();

  cnt_seq_decoder #(.MAX(15), .MIN(0), .WIDTH(4), .LOCK_N(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  cnt_seq_decoder #(.MAX(9), .MIN(2), .WIDTH(4), .LOCK_N(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  // Reference: the step is the signed distance around the MIN..MAX ring.
  function automatic mdl_t mdl_next(mdl_t m, bit en, int c, int mn, int mx, int lockn);
    mdl_t n;
    int   r, d, sdir;
    bit   in_rng;
    n      = m;
    n.wrap = 0;
    n.rev  = 0;
    n.err  = 0;
    if (!en) return n;
    in_rng = (c >= mn) && (c <= mx);
    if (!m.has_p) begin
      if (in_rng) begin
        n.has_p = 1;
        n.p     = c;
      end else begin
        n.err = 1;
      end
    end else if (!in_rng) begin
      n.err   = 1;
      n.has_p = 0;
      n.trk   = 0;
      n.run   = 0;
    end else begin
      r = mx - mn + 1;
      d = (((c - m.p) % r) + r) % r;
      if (d == 1 || d == r - 1) begin
        sdir   = (d == 1) ? 1 : -1;
        n.p    = c;
        n.wrap = (sdir == 1) ? (c < m.p) : (c > m.p);
        if (m.trk == sdir) begin
          n.run = (m.run + 1 > lockn) ? lockn : m.run + 1;
        end else begin
          n.rev = (m.trk != 0);
          n.trk = sdir;
          n.run = 1;
        end
        n.dir = (sdir == -1);
      end else if (d != 0) begin
        n.err = 1;
        n.p   = c;
        n.trk = 0;
        n.run = 0;
      end
    end
    n.locked = (n.trk != 0) && (n.run >= lockn) && !n.rev && !n.err;
    if (n.err && n.err_cnt < 255) n.err_cnt = n.err_cnt + 1;
    return n;
  endfunction

  function automatic int pick(mdl_t m, int mn, int mx);
    int r;
    r = $urandom_range(0, 9);
    if (!m.has_p || r >= 8) return $urandom_range(0, 15);
    if (r <= 3) return (m.p == mx) ? mn : m.p + 1;
    if (r <= 6) return (m.p == mn) ? mx : m.p - 1;
    return m.p;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag, mdl_t m, logic d, logic l, logic w, logic rv,
                         logic e, logic [7:0] ec);
    chk({tag, ".dir"},     32'(d),  32'(m.dir));
    chk({tag, ".locked"},  32'(l),  32'(m.locked));
    chk({tag, ".wrap"},    32'(w),  32'(m.wrap));
    chk({tag, ".rev"},     32'(rv), 32'(m.rev));
    chk({tag, ".err"},     32'(e),  32'(m.err));
    chk({tag, ".err_cnt"}, 32'(ec), 32'(m.err_cnt));
  endtask

  task automatic check_both();
    chk_all("a", ma, if_a.dir, if_a.locked, if_a.wrap, if_a.rev, if_a.err, if_a.err_cnt);
    chk_all("b", mb, if_b.dir, if_b.locked, if_b.wrap, if_b.rev, if_b.err, if_b.err_cnt);
  endtask

  task automatic step_a(bit en, int c);
    if_a.en     = en;
    if_a.cnt_in = c[3:0];
    if_b.en     = 1'b0;
    @(posedge clk);
    #1;
    ma = mdl_next(ma, en, c, 0, 15, 2);
    mb = mdl_next(mb, 1'b0, 0, 2, 9, 2);
    check_both();
  endtask

  task automatic step_b(bit en, int c);
    if_b.en     = en;
    if_b.cnt_in = c[3:0];
    if_a.en     = 1'b0;
    @(posedge clk);
    #1;
    mb = mdl_next(mb, en, c, 2, 9, 2);
    ma = mdl_next(ma, 1'b0, 0, 0, 15, 2);
    check_both();
  endtask

  task automatic zero_outputs(string tag);
    chk({tag, ".a_locked"},  32'(if_a.locked),  0);
    chk({tag, ".a_dir"},     32'(if_a.dir),     0);
    chk({tag, ".a_wrap"},    32'(if_a.wrap),    0);
    chk({tag, ".a_rev"},     32'(if_a.rev),     0);
    chk({tag, ".a_err"},     32'(if_a.err),     0);
    chk({tag, ".a_err_cnt"}, 32'(if_a.err_cnt), 0);
    chk({tag, ".b_locked"},  32'(if_b.locked),  0);
    chk({tag, ".b_err_cnt"}, 32'(if_b.err_cnt), 0);
  endtask

  initial begin
    bit e;
    int v;
    if_a.en     = 1'b0;
    if_a.cnt_in = '0;
    if_b.en     = 1'b0;
    if_b.cnt_in = '0;
    ma = '{default: 0};
    mb = '{default: 0};
    #12;
    zero_outputs("reset");
    rst_n = 1'b1;

    // Clean up count locks after the third sample
    step_a(1, 0);
    step_a(1, 1);
    chk("lock_not_yet", 32'(if_a.locked), 0);
    step_a(1, 2);
    chk("lock_after_2", 32'(if_a.locked), 1);
    step_a(1, 3);
    for (int i = 4; i <= 15; i++) step_a(1, i);
    step_a(1, 0);
    chk("wrap_up", 32'(if_a.wrap), 1);
    chk("lock_thru_wrap", 32'(if_a.locked), 1);
    step_a(1, 1);
    chk("wrap_once", 32'(if_a.wrap), 0);

    // Reversal and down wrap
    step_a(1, 2);
    step_a(1, 3);
    step_a(1, 3);
    step_a(1, 2);
    chk("rev_pulse", 32'(if_a.rev), 1);
    chk("rev_dir", 32'(if_a.dir), 1);
    chk("rev_unlock", 32'(if_a.locked), 0);
    step_a(1, 1);
    chk("relock_dn", 32'(if_a.locked), 1);
    step_a(1, 0);
    step_a(1, 15);
    chk("wrap_dn", 32'(if_a.wrap), 1);
    step_a(0, 9);
    chk("en_low_quiet", 32'(if_a.err), 0);

    // Asynchronous reset while locked
    #2;
    rst_n = 1'b0;
    #1;
    ma = '{default: 0};
    mb = '{default: 0};
    zero_outputs("mid_reset");
    #1;
    rst_n = 1'b1;

    // Illegal jump, then re-acquire
    step_a(1, 5);
    step_a(1, 6);
    step_a(1, 9);
    chk("bad_step_err", 32'(if_a.err), 1);
    chk("bad_step_cnt", 32'(if_a.err_cnt), 1);
    step_a(1, 10);
    step_a(1, 11);
    chk("relock_up", 32'(if_a.locked), 1);

    // Narrow range: counter reset value 0 is out of range
    step_b(1, 0);
    chk("b_oor_err", 32'(if_b.err), 1);
    step_b(1, 2);
    chk("b_first_ok", 32'(if_b.err), 0);
    step_b(1, 3);
    step_b(1, 4);
    chk("b_lock", 32'(if_b.locked), 1);
    step_b(1, 9);
    step_b(1, 2);
    chk("b_wrap", 32'(if_b.wrap), 1);

    for (int i = 0; i < 500; i++) begin
      e = ($urandom_range(0, 9) != 0);
      v = pick(ma, 0, 15);
      step_a(e, v);
    end
    for (int i = 0; i < 500; i++) begin
      e = ($urandom_range(0, 9) != 0);
      v = pick(mb, 2, 9);
      step_b(e, v);
    end

    // Saturate the error tally
    for (int i = 0; i < 300; i++) step_b(1, $urandom_range(10, 15));
    chk("err_sat", 32'(if_b.err_cnt), 255);
    step_b(1, 0);
    chk("err_sat_hold", 32'(if_b.err_cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_seq_decoder.md
# cnt_seq_decoder

Receive-side companion to the up/down wrap counter. The block samples a MIN..MAX count stream and recovers the counting direction, with lock status. It flags wrap-arounds, direction reversals and illegal steps. It sits beside the counter on the lab board and drives the direction/status LEDs and the error tally shown on the display.

## Interface
- MAX, 15: upper count bound; the wrap-up source value.
- MIN, 0: lower count bound; the wrap-down source value. MAX − MIN ≥ 2 is required, otherwise up and down steps are ambiguous.
- WIDTH, 4: width of cnt_in.
- LOCK_N, 2: consecutive same-direction steps required to assert locked (1..15).
- clk  in  1  clock; all state is updated on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  sample enable; cnt_in is ignored when 0.
- cnt_in  in  WIDTH  observed count value.
- dir  out  1  recovered direction: 0 = up, 1 = down (same encoding as the counter's U_D).
- locked  out  1  direction is trusted.
- wrap  out  1  one-cycle pulse: a legal MAX→MIN or MIN→MAX step was accepted.
- rev  out  1  one-cycle pulse: a legal step reversed the tracked direction.
- err  out  1  one-cycle pulse: an illegal step or out-of-range sample.
- err_cnt  out  8  saturating count of err pulses.

## Operation
- The step class is computed from the stored previous sample p and the new sample c.
- Any c outside [MIN, MAX] is BAD.
- c == p is HOLD.
- UP: c == p+1 with p ≠ MAX, or p == MAX and c == MIN (wrap).
- DN: c == p−1 with p ≠ MIN, or p == MIN and c == MAX (wrap).
- Every other combination is BAD.
- FSM states are S_EMPTY (no valid p), S_ACQ (p valid, direction unknown), S_UP and S_DN. A run counter (4 bits, saturating at LOCK_N) tracks consecutive same-direction steps.
- S_EMPTY:
  - In-range sample: store p, go to S_ACQ.
  - Out-of-range sample: err, stay in S_EMPTY.
- S_ACQ:
  - UP: go to S_UP, run = 1.
  - DN: go to S_DN, run = 1.
  - HOLD: no change.
  - BAD: err, then re-acquire (below).
- S_UP:
  - UP: run++.
  - DN: rev pulse, go to S_DN, run = 1.
  - HOLD: no change.
  - BAD: err, then re-acquire (below).
- S_DN: mirror of S_UP.
- Re-acquire after BAD: if c is in range, p = c and go to S_ACQ; otherwise go to S_EMPTY.
- p is updated to c on every accepted in-range sample.
- dir takes the direction of the current S_UP/S_DN state. It holds its last value in S_ACQ/S_EMPTY.
- locked = (state is S_UP or S_DN) and run ≥ LOCK_N. It drops the same cycle as any rev or err.
- wrap fires only on legal wrap steps, including a wrap step that is also a reversal (rev and wrap both pulse).
- err_cnt saturates at 255 and does not roll over.
- en = 0: no state, p, run or pulse update; all pulses are 0 that cycle.

## Timing
- Reset values: state S_EMPTY, p = 0 (invalid), run 0, dir 0, locked 0, wrap 0, rev 0, err 0, err_cnt 0.
- Reset asserted mid-stream: all of the above are applied immediately (asynchronously).
- First sample after reset release is never flagged as an error when in range. Note the counter's reset value 0 is out of range when MIN > 0.
- All outputs are registered. cnt_in sampled at posedge k appears in dir/locked/pulses after posedge k, so they are valid through cycle k+1.
- Pulses are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Minimum time to lock from reset with a clean stream: LOCK_N+1 enabled samples.

## Structure
- Package cnt_dec_pkg holds:
  - state enum (S_EMPTY, S_ACQ, S_UP, S_DN);
  - step enum (STEP_UP, STEP_DN, STEP_HOLD, STEP_BAD);
  - DIR_UP = 0 and DIR_DN = 1 constants.
- Sub-module cnt_step_classify: purely combinational. Inputs p, c, MIN, MAX; outputs step class and is_wrap. It is reused by the counter's own assertion checker.
- The top level holds the FSM, the p register, the run and err counters, and the pulse registers.

## Test plan
- Defaults, en = 1, stream 0,1,2,3 → locked rises on the cycle after sample 2; dir = 0; no err.
- Stream 14,15,0,1 → wrap pulse once, after sample 0; locked stays 1; dir = 0.
- Stream 3,2,1,0,15 after an up-lock → rev pulse after sample 2, dir = 1, locked drops then re-asserts after sample 1; wrap pulse after sample 15.
- Stream 5,6,9,10,11 → err after sample 9, err_cnt = 1, state goes to S_ACQ; 10, 11 re-lock up.
- MIN = 2, MAX = 9, stream 0,2,3,4 → err after 0 (out of range), state stays S_EMPTY; then normal acquisition and lock after sample 4.
- Apply reset mid-lock, and separately force 300 errors → all outputs zero immediately on reset; err_cnt holds at 255 after the forced errors.
